btn_conditioner: RTL and testbench

Front-end conditioning for the board's eight push-buttons, sitting between the raw `btn` pins and the stopwatch, timer and mode-select logic. Each button is synchronised and debounced. The block then emits clean levels and single-cycle events: press, release, long-press and auto-repeat. It also emits a dedicated all-buttons chord pulse used for stopwatch/timer mode toggling, so downstream blocks never edge-detect raw inputs themselves.

---
 rtl/btn_conditioner.sv | 106 ++++++++++
 tb/tb_btn_conditioner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Push-button front end: two-flop synchroniser, per-bit debounce, and registered
// press/release/long/auto-repeat pulses plus an all-buttons chord pulse.
module btn_conditioner #(
  parameter int N_BTN           = 8,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int REPEAT_CYCLES   = 2400000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             all_press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;
  logic [N_BTN-1:0] level_next;
  logic [N_BTN-1:0] long_hit;
  logic [N_BTN-1:0] rep_wrap;
  logic [N_BTN-1:0] quiet;
  logic             chord_next;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_bit
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;
    logic          differs;
    logic          rep_active;

    assign differs        = sync_q2[i] != btn_level[i];
    assign level_next[i]  = (differs && db_cnt == DB_LAST) ? sync_q2[i] : btn_level[i];
    // Hold counter is one short of LONG_CYCLES: the long pulse lands this edge.
    assign long_hit[i]    = btn_level[i] && hold_cnt == HOLD_PRE;
    assign rep_active     = btn_level[i] && hold_cnt == HOLD_MAX;
    assign rep_wrap[i]    = rep_active && rep_cnt == REP_LAST;

    // NOTE: the per-bit counters are ordinary registers, not a RAM, so they get
    // a real reset; a reset must never leave a stale debounce or hold count.
    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt   <= '0;
        hold_cnt <= '0;
        rep_cnt  <= '0;
      end else begin
        if (!differs || db_cnt == DB_LAST) db_cnt <= '0;
        else                               db_cnt <= db_cnt + DW'(1);

        if (!btn_level[i])              hold_cnt <= '0;
        else if (hold_cnt != HOLD_MAX)  hold_cnt <= hold_cnt + HW'(1);

        if (!rep_active || rep_wrap[i]) rep_cnt <= '0;
        else                            rep_cnt <= rep_cnt + RW'(1);
      end
    end
  end

  // Chord suppression follows the level that will be visible alongside the pulse.
  assign chord_next = &level_next;
  assign quiet      = {N_BTN{~chord_next}};

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_long    <= '0;
      btn_repeat  <= '0;
      all_press   <= 1'b0;
    end else begin
      btn_level   <= level_next;
      btn_press   <= level_next & ~btn_level;
      btn_release <= ~level_next & btn_level;
      btn_long    <= level_next & long_hit & quiet;
      // Masking with level_next lets a coincident release win over a repeat.
      btn_repeat  <= level_next & (~btn_level | long_hit | rep_wrap) & quiet;
      all_press   <= chord_next & ~(&btn_level);
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: expected pulses are queued with their due
// cycle when stimulus is applied and compared against every output each cycle.
module tb_btn_conditioner;

  localparam int N = 8;
  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;
  logic         all_press;

  btn_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .btn_repeat(btn_repeat), .all_press(all_press)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           at;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
    logic [N-1:0] rep;
    logic         allp;
  } ev_t;

  ev_t          sb[$];
  int           cyc    = 0;
  int           errors = 0;
  int           checks = 0;
  logic [N-1:0] exp_level = '0;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic sched(input int at, input logic [N-1:0] p, input logic [N-1:0] r,
                       input logic [N-1:0] lg, input logic [N-1:0] rp, input logic a);
    ev_t e;
    e.at = at; e.press = p; e.rel = r; e.lng = lg; e.rep = rp; e.allp = a;
    sb.push_back(e);
  endtask

  task automatic purge_future();
    for (int j = sb.size() - 1; j >= 0; j--)
      if (sb[j].at > cyc) sb.delete(j);
  endtask

  // Advance n edges; after each edge pop the events due and check every output.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      logic         rst_s;
      logic [N-1:0] ep, er, el, erp;
      logic         ea;
      rst_s = rst;
      @(posedge clk);
      cyc++;
      #1;
      ep = '0; er = '0; el = '0; erp = '0; ea = 1'b0;
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at == cyc) begin
          ep  |= sb[j].press;
          er  |= sb[j].rel;
          el  |= sb[j].lng;
          erp |= sb[j].rep;
          ea  |= sb[j].allp;
          sb.delete(j);
        end
      end
      if (rst_s) exp_level = '0;
      else       exp_level = (exp_level | ep) & ~er;
      check("level",   btn_level,   exp_level);
      check("press",   btn_press,   ep);
      check("release", btn_release, er);
      check("long",    btn_long,    el);
      check("repeat",  btn_repeat,  erp);
      check("all",     {7'b0, all_press}, {7'b0, ea});
    end
  endtask

  int p;
  int c2;

  initial begin
    rst = 1'b1;
    btn = '1;

    // Reset with all buttons held: chord press on the 6th edge after release.
    tick(3);
    rst = 1'b0;
    sched(cyc + 6, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1);
    tick(8);
    btn = '0;
    sched(cyc + 6, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0);
    tick(10);

    // Bounce on bit 0: only the final stable rise counts.
    btn[0] = 1'b1; tick(2);
    btn[0] = 1'b0; tick(2);
    btn[0] = 1'b1;
    sched(cyc + 6, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0);
    tick(10);
    btn[0] = 1'b0;
    sched(cyc + 6, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0);
    tick(10);

    // Long hold on bit 3; the release lands on a repeat slot and wins.
    btn[3] = 1'b1;
    p = cyc + 6;
    sched(p,      8'h08, 8'h00, 8'h00, 8'h08, 1'b0);
    sched(p + 20, 8'h00, 8'h00, 8'h08, 8'h08, 1'b0);
    sched(p + 25, 8'h00, 8'h00, 8'h00, 8'h08, 1'b0);
    sched(p + 30, 8'h00, 8'h00, 8'h00, 8'h08, 1'b0);
    sched(p + 35, 8'h00, 8'h00, 8'h00, 8'h08, 1'b0);
    sched(p + 40, 8'h00, 8'h08, 8'h00, 8'h00, 1'b0);
    tick(p + 34 - cyc);
    btn[3] = 1'b0;
    tick(16);

    // Short hold on bit 3: release before the long threshold.
    btn[3] = 1'b1;
    p = cyc + 6;
    sched(p, 8'h08, 8'h00, 8'h00, 8'h08, 1'b0);
    tick(p + 10 - cyc);
    btn[3] = 1'b0;
    sched(p + 16, 8'h00, 8'h08, 8'h00, 8'h00, 1'b0);
    tick(12);

    // Chord: bits 0-6 then bit 7; long/repeat suppressed while all held.
    btn = 8'h7F;
    sched(cyc + 6, 8'h7F, 8'h00, 8'h00, 8'h7F, 1'b0);
    tick(10);
    btn[7] = 1'b1;
    c2 = cyc;
    sched(c2 + 6, 8'h80, 8'h00, 8'h00, 8'h00, 1'b1);
    tick(36);
    btn[2] = 1'b0;
    sched(c2 + 42, 8'h00, 8'h04, 8'h00, 8'h00, 1'b0);
    sched(c2 + 46, 8'h00, 8'h00, 8'h00, 8'hFB, 1'b0);
    tick(8);
    btn[2] = 1'b1;
    sched(c2 + 50, 8'h04, 8'h00, 8'h00, 8'h00, 1'b1);
    tick(8);
    btn = '0;
    sched(c2 + 58, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0);
    tick(12);

    // One-cycle reset mid-hold: no release, then a fresh press.
    btn[3] = 1'b1;
    p = cyc + 6;
    sched(p,      8'h08, 8'h00, 8'h00, 8'h08, 1'b0);
    sched(p + 20, 8'h00, 8'h00, 8'h08, 8'h08, 1'b0);
    sched(p + 25, 8'h00, 8'h00, 8'h00, 8'h08, 1'b0);
    tick(p + 22 - cyc);
    rst = 1'b1;
    purge_future();
    tick(1);
    rst = 1'b0;
    sched(cyc + 6, 8'h08, 8'h00, 8'h00, 8'h08, 1'b0);
    tick(12);
    btn[3] = 1'b0;
    sched(cyc + 6, 8'h00, 8'h08, 8'h00, 8'h00, 1'b0);
    tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
